hw_heartbeat_monitor: RTL and testbench

Receive-side checker for the board heartbeat LED signal. The heartbeat source toggles its output every FREQ/2+1 clock cycles. This block synchronises that signal, measures the interval between toggles and checks it against a tolerance window. It reports locked/alive status, sticky fault status with cause, and the last measured interval. It sits beside the Nios II system as a liveness watchdog for an upstream clock domain or board.

---
 rtl/hw_mon_pkg.sv | 29 ++
 rtl/hw_sync_edge.sv | 40 ++++
 rtl/hw_heartbeat_monitor.sv | 168 ++++++++++++++++
 tb/tb_hw_heartbeat_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hw_mon_pkg.sv
// ---------------------------------------------------------------------------
// hw_mon_pkg
// Shared definitions for the heartbeat monitor slice:
//   monState_t    - monitor FSM state encoding (also driven out as debug code)
//   CAUSE_*       - fault cause codes reported on oCAUSE
//   CNT_MAX       - saturation value of the 32-bit interval counter
//   halfNom()     - nominal heartbeat half-period in clock cycles
// ---------------------------------------------------------------------------
package hw_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        ALIVE = 2'd2,
        FAULT = 2'd3
    } monState_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_SHORT   = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // The heartbeat source toggles every FREQ/2+1 cycles of its clock.
    function automatic logic [31:0] halfNom(input int unsigned freq);
        return 32'(freq / 2 + 1);
    endfunction

endpackage

// File: rtl/hw_sync_edge.sv
// ---------------------------------------------------------------------------
// hw_sync_edge
// Two-flop synchroniser for an asynchronous level input, followed by an
// any-edge detector with a registered one-cycle pulse output. A change on
// iBEAT shows up as oEDGE high exactly 3 iCLK cycles later.
// Ports:
//   iCLK  - clock
//   iRST  - synchronous active-high reset, clears all flops to 0
//   iBEAT - asynchronous level input
//   oEDGE - one-cycle pulse per transition (rise or fall) of iBEAT
// ---------------------------------------------------------------------------
module hw_sync_edge
    import hw_mon_pkg::*;
(
    input  logic iCLK,
    input  logic iRST,
    input  logic iBEAT,
    output logic oEDGE
);

    logic sync1;
    logic sync2;
    logic prevQ;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prevQ <= 1'b0;
            oEDGE <= 1'b0;
        end else begin
            sync1 <= iBEAT;
            sync2 <= sync1;
            prevQ <= sync2;
            // Pulse is registered so downstream sees a clean flop output.
            oEDGE <= sync2 ^ prevQ;
        end
    end

endmodule

// File: rtl/hw_heartbeat_monitor.sv
// ---------------------------------------------------------------------------
// hw_heartbeat_monitor
// Liveness watchdog for a toggling heartbeat signal. Measures the number of
// cycles between heartbeat transitions, checks each interval against the
// window [HALF_MIN, HALF_MAX] and reports lock / alive / fault status.
// Parameters:
//   FREQ       - clock frequency in Hz (nominal half-period FREQ/2+1)
//   TOL        - allowed deviation in cycles; HALF_NOM-TOL must be >= 2
//   LOCK_EDGES - consecutive good intervals needed to declare alive (>= 1)
// Ports:
//   iCLK    - system clock
//   iRST    - synchronous active-high reset
//   iBEAT   - heartbeat input, asynchronous to iCLK
//   iCLR    - single-cycle clear of fault/lock state
//   oALIVE  - high while in ALIVE
//   oFAULT  - sticky fault flag
//   oCAUSE  - 00 none, 01 interval short, 10 timeout
//   oPERIOD - last measured interval in cycles
//   oSTATE  - debug state code (IDLE/LOCK/ALIVE/FAULT = 0..3)
// ---------------------------------------------------------------------------
module hw_heartbeat_monitor
    import hw_mon_pkg::*;
#(
    parameter int unsigned FREQ       = 120000000,
    parameter int unsigned TOL        = FREQ / 16,
    parameter int unsigned LOCK_EDGES = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iBEAT,
    input  logic        iCLR,
    output logic        oALIVE,
    output logic        oFAULT,
    output logic [1:0]  oCAUSE,
    output logic [31:0] oPERIOD,
    output logic [1:0]  oSTATE
);

    localparam logic [31:0] HALF_NOM = halfNom(FREQ);
    localparam logic [31:0] HALF_MIN = HALF_NOM - TOL;
    localparam logic [31:0] HALF_MAX = HALF_NOM + TOL;

    // goodCnt only needs to reach LOCK_EDGES-1: the LOCK_EDGES-th good
    // interval moves straight to ALIVE instead of incrementing.
    localparam int unsigned   GW        = (LOCK_EDGES > 1) ? $clog2(LOCK_EDGES) : 1;
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_EDGES - 1);

    logic          edgePulse;
    logic [31:0]   cnt;
    monState_t     state;
    monState_t     stateNext;
    logic [GW-1:0] goodCnt;
    logic [GW-1:0] goodNext;
    logic [1:0]    causeQ;
    logic [1:0]    causeNext;
    logic [31:0]   periodQ;
    logic [31:0]   periodNext;
    logic          aliveQ;
    logic          faultQ;
    logic          isShort;
    logic          isGood;
    logic          atLimit;

    hw_sync_edge uSyncEdge (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iBEAT (iBEAT),
        .oEDGE (edgePulse)
    );

    // Interval counter: cnt on an edge cycle is the interval just completed.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt <= '0;
        end else if (edgePulse) begin
            cnt <= 32'd1;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign isShort = (cnt < HALF_MIN);
    assign isGood  = (cnt >= HALF_MIN) && (cnt <= HALF_MAX);
    // Only meaningful on a non-edge cycle: an edge at HALF_MAX is good.
    assign atLimit = (cnt == HALF_MAX);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= IDLE;
            goodCnt <= '0;
            causeQ  <= CAUSE_NONE;
            periodQ <= '0;
            aliveQ  <= 1'b0;
            faultQ  <= 1'b0;
        end else begin
            state   <= stateNext;
            goodCnt <= goodNext;
            causeQ  <= causeNext;
            periodQ <= periodNext;
            aliveQ  <= (stateNext == ALIVE);
            faultQ  <= (stateNext == FAULT);
        end
    end

    always_comb begin
        stateNext  = state;
        goodNext   = goodCnt;
        causeNext  = causeQ;
        periodNext = periodQ;
        if (iCLR) begin
            // Clear wins over any coincident edge; that edge is dropped.
            stateNext  = IDLE;
            goodNext   = '0;
            causeNext  = CAUSE_NONE;
            periodNext = '0;
        end else begin
            case (state)
                IDLE: begin
                    // First edge only starts the measurement.
                    if (edgePulse) begin
                        stateNext = LOCK;
                        goodNext  = '0;
                    end
                end
                LOCK, ALIVE: begin
                    if (edgePulse) begin
                        periodNext = cnt;
                        if (isGood) begin
                            if (state == LOCK) begin
                                if (goodCnt == GOOD_LAST) begin
                                    stateNext = ALIVE;
                                end else begin
                                    goodNext = goodCnt + 1'b1;
                                end
                            end
                        end else if (isShort) begin
                            stateNext = FAULT;
                            causeNext = CAUSE_SHORT;
                        end else begin
                            // Over-long interval; normally caught by atLimit first.
                            stateNext = FAULT;
                            causeNext = CAUSE_TIMEOUT;
                        end
                    end else if (atLimit) begin
                        stateNext = FAULT;
                        causeNext = CAUSE_TIMEOUT;
                    end
                end
                FAULT: begin
                    // Cause is frozen; the interval is still reported.
                    if (edgePulse) begin
                        periodNext = cnt;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    assign oALIVE  = aliveQ;
    assign oFAULT  = faultQ;
    assign oCAUSE  = causeQ;
    assign oPERIOD = periodQ;
    assign oSTATE  = state;

endmodule

// File: tb/tb_hw_heartbeat_monitor.sv
// ---------------------------------------------------------------------------
// tb_hw_heartbeat_monitor
// Directed bench for hw_heartbeat_monitor with FREQ=20 (nominal 11 cycles),
// TOL=2 (window 9..13), LOCK_EDGES=3. The stimulus thread pushes expected
// output snapshots tagged with the cycle they must appear on; a monitor on
// the falling edge pops and compares them.
// Cycle numbering: cyc == N after the N-th rising edge. A beat toggled in
// cycle P gives an edge pulse in cycle P+3 and new outputs in cycle P+4.
// ---------------------------------------------------------------------------
module tb_hw_heartbeat_monitor;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOCK  = 2'd1;
    localparam logic [1:0] S_ALIVE = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic        iCLK;
    logic        iRST;
    logic        iBEAT;
    logic        iCLR;
    logic        oALIVE;
    logic        oFAULT;
    logic [1:0]  oCAUSE;
    logic [31:0] oPERIOD;
    logic [1:0]  oSTATE;

    int cyc    = 0;
    int cmpCnt = 0;
    int errCnt = 0;

    // {cycle[15:0], alive, fault, cause[1:0], period[31:0], state[1:0]}
    logic [53:0] exp_q[$];
    string       name_q[$];

    hw_heartbeat_monitor #(
        .FREQ       (20),
        .TOL        (2),
        .LOCK_EDGES (3)
    ) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iBEAT   (iBEAT),
        .iCLR    (iCLR),
        .oALIVE  (oALIVE),
        .oFAULT  (oFAULT),
        .oCAUSE  (oCAUSE),
        .oPERIOD (oPERIOD),
        .oSTATE  (oSTATE)
    );

    // ---------------- clock / reset ----------------
    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    always @(posedge iCLK) cyc <= cyc + 1;

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic toggleBeat();
        iBEAT = ~iBEAT;
    endtask

    task automatic expectAt(input string name, input int at, input logic a, input logic f,
                            input logic [1:0] c, input logic [31:0] p, input logic [1:0] s);
        exp_q.push_back({at[15:0], a, f, c, p, s});
        name_q.push_back(name);
    endtask

    task automatic pulseClr(input string name);
        int t;
        t = cyc;
        iCLR = 1'b1;
        expectAt(name, t + 1, 1'b0, 1'b0, 2'b00, 32'd0, S_IDLE);
        step(1);
        iCLR = 1'b0;
    endtask

    // Four toggles 11 cycles apart from any non-locked start; returns in the
    // cycle of the fourth toggle, which makes the monitor ALIVE 4 cycles later.
    task automatic relock(input string name);
        int t;
        t = cyc;
        toggleBeat();
        expectAt({name, "_first"}, t + 4, 1'b0, 1'b0, 2'b00, 32'd0, S_LOCK);
        step(11);
        t = cyc;
        toggleBeat();
        expectAt({name, "_good1"}, t + 4, 1'b0, 1'b0, 2'b00, 32'd11, S_LOCK);
        step(11);
        t = cyc;
        toggleBeat();
        expectAt({name, "_good2"}, t + 4, 1'b0, 1'b0, 2'b00, 32'd11, S_LOCK);
        step(11);
        t = cyc;
        toggleBeat();
        expectAt({name, "_pre_alive"}, t + 3, 1'b0, 1'b0, 2'b00, 32'd11, S_LOCK);
        expectAt({name, "_alive"}, t + 4, 1'b1, 1'b0, 2'b00, 32'd11, S_ALIVE);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge iCLK) begin
        logic [53:0] e;
        string       nm;
        while (exp_q.size() > 0 && int'(exp_q[0][53:38]) <= cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            cmpCnt++;
            if (int'(e[53:38]) < cyc) begin
                errCnt++;
                $display("FAIL %s: check for cycle %0d not reached in order (now %0d)",
                         nm, int'(e[53:38]), cyc);
            end else if ({oALIVE, oFAULT, oCAUSE, oPERIOD, oSTATE} !== e[37:0]) begin
                errCnt++;
                $display("FAIL %s @cyc %0d: got alive=%b fault=%b cause=%b period=%0d state=%b, want alive=%b fault=%b cause=%b period=%0d state=%b",
                         nm, cyc, oALIVE, oFAULT, oCAUSE, oPERIOD, oSTATE,
                         e[37], e[36], e[35:34], e[33:2], e[1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t;
        iRST  = 1'b1;
        iBEAT = 1'b0;
        iCLR  = 1'b0;

        // Reset state
        step(3);
        expectAt("reset", cyc, 1'b0, 1'b0, 2'b00, 32'd0, S_IDLE);
        iRST = 1'b0;
        step(2);
        expectAt("idle_wait", cyc + 6, 1'b0, 1'b0, 2'b00, 32'd0, S_IDLE);
        step(8);

        // Nominal toggling locks after 1 + 3 edges
        relock("lock");

        // Interval of exactly HALF_MAX is good, then a stuck beat times out
        step(13);
        t = cyc;
        toggleBeat();
        expectAt("max_edge_good", t + 4, 1'b1, 1'b0, 2'b00, 32'd13, S_ALIVE);
        expectAt("pre_timeout", t + 16, 1'b1, 1'b0, 2'b00, 32'd13, S_ALIVE);
        expectAt("timeout", t + 17, 1'b0, 1'b1, 2'b10, 32'd13, S_FAULT);
        step(20);

        // In FAULT: period keeps updating, first cause is kept
        t = cyc;
        toggleBeat();
        expectAt("fault_period", t + 4, 1'b0, 1'b1, 2'b10, 32'd20, S_FAULT);
        step(5);
        t = cyc;
        toggleBeat();
        expectAt("fault_cause_kept", t + 4, 1'b0, 1'b1, 2'b10, 32'd5, S_FAULT);
        step(6);

        // Clear from FAULT, relock
        pulseClr("clr_fault");
        step(3);
        relock("relock1");

        // Short interval in ALIVE
        step(8);
        t = cyc;
        toggleBeat();
        expectAt("pre_short", t + 3, 1'b1, 1'b0, 2'b00, 32'd11, S_ALIVE);
        expectAt("short", t + 4, 1'b0, 1'b1, 2'b01, 32'd8, S_FAULT);
        step(6);
        pulseClr("clr_short");
        step(3);
        relock("relock2");
        step(5);

        // Reset while ALIVE, then held reset with a toggling beat
        iRST = 1'b1;
        t = cyc;
        expectAt("rst_alive", t + 1, 1'b0, 1'b0, 2'b00, 32'd0, S_IDLE);
        step(1);
        t = cyc;
        toggleBeat();
        expectAt("rst_held1", t + 5, 1'b0, 1'b0, 2'b00, 32'd0, S_IDLE);
        step(11);
        t = cyc;
        toggleBeat();
        expectAt("rst_held2", t + 5, 1'b0, 1'b0, 2'b00, 32'd0, S_IDLE);
        step(11);
        iBEAT = 1'b0;
        step(3);
        iRST = 1'b0;
        expectAt("rst_release", cyc + 6, 1'b0, 1'b0, 2'b00, 32'd0, S_IDLE);
        step(8);

        // Clear coincident with an edge pulse in LOCK
        t = cyc;
        toggleBeat();
        expectAt("u_first", t + 4, 1'b0, 1'b0, 2'b00, 32'd0, S_LOCK);
        step(11);
        t = cyc;
        toggleBeat();
        step(3);
        iCLR = 1'b1;
        expectAt("clr_on_edge", t + 4, 1'b0, 1'b0, 2'b00, 32'd0, S_IDLE);
        step(1);
        iCLR = 1'b0;
        step(7);
        t = cyc;
        toggleBeat();
        expectAt("after_clr_first", t + 4, 1'b0, 1'b0, 2'b00, 32'd0, S_LOCK);
        step(11);
        t = cyc;
        toggleBeat();
        expectAt("after_clr_good1", t + 4, 1'b0, 1'b0, 2'b00, 32'd11, S_LOCK);
        step(11);
        t = cyc;
        toggleBeat();
        expectAt("after_clr_good2", t + 4, 1'b0, 1'b0, 2'b00, 32'd11, S_LOCK);
        step(11);
        t = cyc;
        toggleBeat();
        expectAt("after_clr_alive", t + 4, 1'b1, 1'b0, 2'b00, 32'd11, S_ALIVE);
        step(10);

        // ---------------- final report ----------------
        while (name_q.size() > 0) begin
            string nm;
            nm = name_q.pop_front();
            void'(exp_q.pop_front());
            cmpCnt++;
            errCnt++;
            $display("FAIL %s: check never performed (still queued at cycle %0d)", nm, cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule
